// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage (master) and memory (slave).
interface ifetch_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ack;
    logic [WIDTH-1:0] rdata;

    modport master (output req, addr, input  ack, rdata);
    modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, runs the imem handshake and presents ir/pc to decode.
// Optional IFETCH_RESTART_EN adds a restart input that leaves HALT and refetches from RESET_PC.
module ifetch #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    ifetch_if.master         imem,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    output logic [WIDTH-1:0] pc,
    input  logic             ex_stall,
    input  logic             halt,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
`ifdef IFETCH_RESTART_EN
    input  logic             restart,
`endif
    output logic             halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] w_addr_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] w_ir_nxt;
    logic             r_halted;
    logic             w_halted_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_addr   <= w_addr_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_addr_nxt   = r_addr;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_halted_nxt = r_halted;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = RESET_PC;
            end
            S_REQ: begin
                // req is always high here, so an ack can only be taken against a live request
                if (imem.ack) begin
                    w_ir_nxt    = imem.rdata;
                    w_pc_nxt    = r_addr;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ex_stall) begin
                    if (halt) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALT;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQ;
                        w_addr_nxt  = br_taken ? br_target : r_pc + WIDTH'(1);
                    end
                end
            end
            S_HALT: begin
`ifdef IFETCH_RESTART_EN
                if (restart) begin
                    w_halted_nxt = 1'b0;
                    w_pc_nxt     = RESET_PC;
                    w_addr_nxt   = RESET_PC;
                    w_req_nxt    = 1'b1;
                    w_state_nxt  = S_REQ;
                end
`else
                w_state_nxt = S_HALT;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign imem.req  = r_req;
    assign imem.addr = r_addr;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign ir_valid  = (r_state == S_EXEC);

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized fetch traffic against a transaction-level model.
module tb_ifetch;
    localparam int           W        = 16;
    localparam logic [W-1:0] RESET_PC = 16'h0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] ir;
    logic         ir_valid;
    logic [W-1:0] pc;
    logic         ex_stall;
    logic         halt;
    logic         br_taken;
    logic [W-1:0] br_target;
    logic         halted;
`ifdef IFETCH_RESTART_EN
    logic         restart;
`endif

    int n_vec = 0;
    int n_err = 0;

    ifetch_if #(.WIDTH(W)) imem ();

    ifetch #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (imem),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .ex_stall  (ex_stall),
        .halt      (halt),
        .br_taken  (br_taken),
        .br_target (br_target),
`ifdef IFETCH_RESTART_EN
        .restart   (restart),
`endif
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem.ack   = 1'b0;
        imem.rdata = '0;
        ex_stall   = 1'b0;
        halt       = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
`ifdef IFETCH_RESTART_EN
        restart    = 1'b0;
`endif
    endtask

    // Leaves the bench mid-cycle in IDLE; the next tick lands in the first REQ cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Memory acknowledges the current request at the next edge.
    task automatic fetch_now(input logic [W-1:0] data);
        imem.ack   = 1'b1;
        imem.rdata = data;
        tick();
        imem.ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0h exp=0", imem.req); end
        n_vec++; if (imem.addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr got=%0h exp=%0h", imem.addr, RESET_PC); end
        n_vec++; if (ir !== 16'h0000) begin n_err++; $display("FAIL rst_ir got=%0h exp=0", ir); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid got=%0h exp=0", ir_valid); end
        n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL rst_pc got=%0h exp=%0h", pc, RESET_PC); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        #2 rst_n = 1'b1;
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL idle_req got=%0h exp=0", imem.req); end
        tick();
        n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL first_req got=%0h exp=1", imem.req); end
        n_vec++; if (imem.addr !== RESET_PC) begin n_err++; $display("FAIL first_addr got=%0h exp=%0h", imem.addr, RESET_PC); end
    endtask

    task automatic test_first_fetch();
        fetch_now(16'h2401);
        n_vec++; if (ir !== 16'h2401) begin n_err++; $display("FAIL ff_ir got=%0h exp=2401", ir); end
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL ff_pc got=%0h exp=0", pc); end
        n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL ff_valid got=%0h exp=1", ir_valid); end
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL ff_req_drop got=%0h exp=0", imem.req); end
        tick();
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL ff_valid_1cyc got=%0h exp=0", ir_valid); end
        n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL ff_next_req got=%0h exp=1", imem.req); end
        n_vec++; if (imem.addr !== 16'h0001) begin n_err++; $display("FAIL ff_next_addr got=%0h exp=1", imem.addr); end
    endtask

    task automatic test_ack_wait();
        fetch_now(16'h1111);
        br_taken  = 1'b1;
        br_target = 16'h0005;
        tick();
        br_taken  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                imem.ack   = 1'b1;
                imem.rdata = 16'hBEEF;
            end
            n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d] got=%0h exp=1", i, imem.req); end
            n_vec++; if (imem.addr !== 16'h0005) begin n_err++; $display("FAIL wait_addr[%0d] got=%0h exp=5", i, imem.addr); end
            n_vec++; if (ir !== 16'h1111) begin n_err++; $display("FAIL wait_ir[%0d] got=%0h exp=1111", i, ir); end
            tick();
        end
        imem.ack = 1'b0;
        n_vec++; if (ir !== 16'hBEEF) begin n_err++; $display("FAIL wait_ir_after got=%0h exp=beef", ir); end
        n_vec++; if (pc !== 16'h0005) begin n_err++; $display("FAIL wait_pc_after got=%0h exp=5", pc); end
        n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid got=%0h exp=1", ir_valid); end
    endtask

    task automatic test_branch();
        br_taken  = 1'b1;
        br_target = 16'h0040;
        tick();
        br_taken  = 1'b0;
        n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL br_req got=%0h exp=1", imem.req); end
        n_vec++; if (imem.addr !== 16'h0040) begin n_err++; $display("FAIL br_addr got=%0h exp=40", imem.addr); end
        fetch_now(16'h7A7A);
        n_vec++; if (pc !== 16'h0040) begin n_err++; $display("FAIL br_pc got=%0h exp=40", pc); end
        n_vec++; if (ir !== 16'h7A7A) begin n_err++; $display("FAIL br_ir got=%0h exp=7a7a", ir); end
    endtask

    task automatic test_wrap();
        br_taken  = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_taken  = 1'b0;
        fetch_now(16'h0C0C);
        n_vec++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pc got=%0h exp=ffff", pc); end
        tick();
        n_vec++; if (imem.addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got=%0h exp=0", imem.addr); end
        n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL wrap_req got=%0h exp=1", imem.req); end
    endtask

    task automatic test_stall();
        fetch_now(16'h5555);
        ex_stall  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, ir_valid); end
            n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got=%0h exp=0", i, imem.req); end
            n_vec++; if (ir !== 16'h5555 || pc !== 16'h0000) begin n_err++; $display("FAIL stall_hold[%0d] got ir=%0h pc=%0h exp ir=5555 pc=0", i, ir, pc); end
            if (i == 2) ex_stall = 1'b0;
            tick();
        end
        br_taken = 1'b0;
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL stall_end_valid got=%0h exp=0", ir_valid); end
        n_vec++; if (imem.req !== 1'b1 || imem.addr !== 16'h1234) begin n_err++; $display("FAIL stall_branch got req=%0h addr=%0h exp req=1 addr=1234", imem.req, imem.addr); end
    endtask

    task automatic test_halt_priority();
        fetch_now(16'hF000);
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0099;
        tick();
        halt      = 1'b0;
        br_taken  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag[%0d] got=%0h exp=1", i, halted); end
            n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL halt_req[%0d] got=%0h exp=0", i, imem.req); end
            n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid[%0d] got=%0h exp=0", i, ir_valid); end
            n_vec++; if (ir !== 16'hF000 || pc !== 16'h1234) begin n_err++; $display("FAIL halt_hold[%0d] got ir=%0h pc=%0h exp ir=f000 pc=1234", i, ir, pc); end
            tick();
        end
    endtask

`ifdef IFETCH_RESTART_EN
    task automatic test_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rs_halted got=%0h exp=0", halted); end
        n_vec++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin n_err++; $display("FAIL rs_req got req=%0h addr=%0h exp req=1 addr=%0h", imem.req, imem.addr, RESET_PC); end
        fetch_now(16'h0101);
        n_vec++; if (pc !== RESET_PC || ir !== 16'h0101) begin n_err++; $display("FAIL rs_fetch got pc=%0h ir=%0h exp pc=%0h ir=0101", pc, ir, RESET_PC); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_vec++; if (imem.addr !== RESET_PC + 16'h0001) begin n_err++; $display("FAIL rs_ignored got=%0h exp=%0h", imem.addr, RESET_PC + 16'h0001); end
    endtask
`endif

    task automatic test_reset_mid_request();
        do_reset();
        tick();
        fetch_now(16'h3333);
        br_taken  = 1'b1;
        br_target = 16'h0007;
        tick();
        br_taken  = 1'b0;
        n_vec++; if (imem.req !== 1'b1 || imem.addr !== 16'h0007) begin n_err++; $display("FAIL mid_setup got req=%0h addr=%0h exp req=1 addr=7", imem.req, imem.addr); end
        #2;
        rst_n      = 1'b0;
        imem.ack   = 1'b1;
        imem.rdata = 16'hDEAD;
        #1;
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop got=%0h exp=0", imem.req); end
        tick();
        n_vec++; if (ir !== 16'h0000 || pc !== RESET_PC) begin n_err++; $display("FAIL mid_late_ack got ir=%0h pc=%0h exp ir=0 pc=%0h", ir, pc, RESET_PC); end
        rst_n = 1'b1;
        tick();
        imem.ack = 1'b0;
        n_vec++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin n_err++; $display("FAIL mid_idle_ack got ir=%0h valid=%0h exp ir=0 valid=0", ir, ir_valid); end
        n_vec++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin n_err++; $display("FAIL mid_refetch got req=%0h addr=%0h exp req=1 addr=%0h", imem.req, imem.addr, RESET_PC); end
    endtask

    // Model: each instruction is one transaction; next fetch address follows from the final EXEC decision.
    task automatic test_random();
        logic [W-1:0] exp_addr;
        logic [W-1:0] data;
        logic [W-1:0] tgt;
        logic         do_halt;
        logic         do_br;
        int           cnt;
        exp_addr = RESET_PC;
        for (int k = 0; k < 150; k++) begin
            cnt = 0;
            while (imem.req !== 1'b1 && cnt < 8) begin
                tick();
                cnt++;
            end
            n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL rnd_req_timeout[%0d] got=%0h exp=1", k, imem.req); end
            n_vec++; if (imem.addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr[%0d] got=%0h exp=%0h", k, imem.addr, exp_addr); end
            repeat ($urandom_range(0, 3)) begin
                tick();
                n_vec++; if (imem.req !== 1'b1 || imem.addr !== exp_addr) begin n_err++; $display("FAIL rnd_hold[%0d] got req=%0h addr=%0h exp req=1 addr=%0h", k, imem.req, imem.addr, exp_addr); end
            end
            data = 16'($urandom);
            fetch_now(data);
            n_vec++; if (ir !== data || pc !== exp_addr || ir_valid !== 1'b1) begin n_err++; $display("FAIL rnd_fetch[%0d] got ir=%0h pc=%0h v=%0h exp ir=%0h pc=%0h v=1", k, ir, pc, ir_valid, data, exp_addr); end
            repeat ($urandom_range(0, 2)) begin
                ex_stall  = 1'b1;
                halt      = 1'($urandom_range(0, 1));
                br_taken  = 1'($urandom_range(0, 1));
                br_target = 16'($urandom);
                tick();
                n_vec++; if (ir_valid !== 1'b1 || ir !== data || imem.req !== 1'b0) begin n_err++; $display("FAIL rnd_stall[%0d] got v=%0h ir=%0h req=%0h exp v=1 ir=%0h req=0", k, ir_valid, ir, imem.req, data); end
            end
            ex_stall  = 1'b0;
            do_halt   = ($urandom_range(0, 15) == 0);
            do_br     = 1'($urandom_range(0, 1));
            tgt       = 16'($urandom);
            halt      = do_halt;
            br_taken  = do_br;
            br_target = tgt;
            tick();
            halt      = 1'b0;
            br_taken  = 1'b0;
            if (do_halt) begin
                n_vec++; if (halted !== 1'b1 || imem.req !== 1'b0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL rnd_halt[%0d] got h=%0h req=%0h v=%0h exp h=1 req=0 v=0", k, halted, imem.req, ir_valid); end
                do_reset();
                tick();
                exp_addr = RESET_PC;
            end else begin
                exp_addr = do_br ? tgt : exp_addr + 16'h0001;
                n_vec++; if (ir_valid !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL rnd_leave[%0d] got v=%0h h=%0h exp v=0 h=0", k, ir_valid, halted); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_first_fetch();
        test_ack_wait();
        test_branch();
        test_wrap();
        test_stall();
        test_halt_priority();
`ifdef IFETCH_RESTART_EN
        test_restart();
`endif
        test_reset_mid_request();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
Instruction fetch stage of the 16-bit PU, directly upstream of the instruction decoder. It owns the program counter and runs the instruction-memory request/acknowledge handshake. It holds the fetched word in an instruction register, presented to the decoder with a one-cycle valid strobe. It consumes halt and branch results back from decode/execute to choose the next PC.

Parameters:
WIDTH, 16, instruction and address width in bits
RESET_PC, 16'h0000, PC value loaded on reset (and on restart)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction memory read request, held until acknowledged
imem_addr  output  WIDTH  word address of the request; stable while imem_req=1
imem_ack  input  1  memory acknowledge; imem_rdata valid in the same cycle
imem_rdata  input  WIDTH  instruction word from memory
ir  output  WIDTH  instruction register, drives the decoder opcode input
ir_valid  output  1  ir holds a new instruction this cycle (one cycle per instruction unless stalled)
pc  output  WIDTH  address of the instruction currently in ir (PC-relative operand source)
ex_stall  input  1  execute not finished; hold ir/pc, stay in EXEC
halt  input  1  decoded HALT, sampled only in EXEC
br_taken  input  1  decoder pcwe, sampled only in EXEC
br_target  input  WIDTH  branch/jump target from the ALU, sampled with br_taken
halted  output  1  core is halted

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, ir=16'h0000, ir_valid=0, imem_req=0, halted=0. Reset mid-request drops imem_req immediately; a late ack is ignored.
- States: IDLE, REQ, EXEC, HALT.
- IDLE: one cycle after reset release, then REQ with imem_req=1, imem_addr=pc_next (RESET_PC).
- REQ: imem_req=1 and imem_addr held constant.
  - imem_ack=1 at edge n: ir<=imem_rdata, pc<=imem_addr, imem_req<=0, state->EXEC; ir_valid=1 during cycle n+1.
  - ack while imem_req=0 is ignored.
  - ack in the first REQ cycle is legal, giving a minimum of 2 cycles per instruction.
- EXEC: ir_valid=1 while in EXEC, and ir/pc stay stable.
  - ex_stall=1: remain in EXEC, halt/br_taken not acted on.
  - ex_stall=0:
    - halt=1 -> HALT (halted<=1, no request). halt has priority over br_taken.
    - else br_taken=1 -> REQ at br_target.
    - else -> REQ at pc+1.
- Next-address arithmetic: pc+1 modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000. br_target is used unmodified.
- HALT: imem_req=0, ir_valid=0, halted=1, ir/pc retain the HALT instruction. Exit only by reset (see Optional Feature).
- Register updates happen only in the cycles listed above. No combinational path from imem_rdata to ir.
- All flops share the clk/rst_n domain. Outputs are registered except ir_valid, which is decoded from state==EXEC.

Optional Feature:
IFETCH_RESTART_EN
- Defined: adds input port restart (1 bit). In HALT, restart=1 at an edge gives halted<=0, pc/imem_addr<=RESET_PC, state->REQ. restart is ignored in other states.
- Undefined: no restart port; HALT is left only via rst_n.

Test Plan:
- Reset release, memory acks on the first request cycle with 16'h2401 at addr 0 -> ir=16'h2401, pc=0, ir_valid high for exactly 1 cycle; next imem_addr=1.
- Memory withholds ack for 3 cycles at addr 5 -> imem_req and imem_addr=5 stable for all 4 cycles; ir updates only after the ack edge.
- EXEC with br_taken=1, br_target=16'h0040 -> next request address 16'h0040. br_taken=1 and halt=1 together -> HALT, no request.
- pc=16'hFFFF, no branch -> next imem_addr=16'h0000.
- ex_stall=1 for 2 cycles with br_taken=1 -> ir_valid held 3 cycles; branch acted on only when ex_stall falls.
- rst_n low while imem_req=1 at addr 7 -> imem_req=0 immediately, ack ignored; after release, fetch restarts at RESET_PC. With IFETCH_RESTART_EN defined, restart in HALT -> fetch from RESET_PC and halted=0.
